// File: rtl/mem_ctrl_pkg.sv
// Shared encodings for the byte-serial RAM port sequencer.
package mem_ctrl_pkg;

    localparam logic [1:0] MEM_LEN_BYTE = 2'b00;
    localparam logic [1:0] MEM_LEN_HALF = 2'b01;
    localparam logic [1:0] MEM_LEN_WORD = 2'b10;

    localparam int RAM_DW = 8;

    localparam logic WRITE_ENABLE  = 1'b1;
    localparam logic WRITE_DISABLE = 1'b0;

    typedef enum logic {
        OWN_IF  = 1'b0,
        OWN_MEM = 1'b1
    } owner_e;

    // Length code 11 is treated as a word access.
    function automatic logic [2:0] len_bytes(input logic [1:0] len);
        case (len)
            MEM_LEN_BYTE: len_bytes = 3'd1;
            MEM_LEN_HALF: len_bytes = 3'd2;
            default:      len_bytes = 3'd4;
        endcase
    endfunction

endpackage

// File: rtl/mem_ctrl.sv
// Arbitrates the 8-bit RAM port between IF and MEM, splitting each access
// into byte transfers and assembling read bytes little-endian.
module mem_ctrl
    import mem_ctrl_pkg::*;
#(
    parameter int RAM_AW = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [31:0]       if_addr,
    output logic [31:0]       if_data,
    output logic              if_done,
    input  logic              mem_req,
    input  logic              mem_we,
    input  logic [1:0]        mem_len,
    input  logic [31:0]       mem_addr,
    input  logic [31:0]       mem_wdata,
    output logic [31:0]       mem_rdata,
    output logic              mem_done,
    output logic              stallreq_if,
    output logic              stallreq_mem,
    output logic [RAM_AW-1:0] ram_a,
    output logic              ram_wr,
    output logic [RAM_DW-1:0] ram_dout,
    input  logic [RAM_DW-1:0] ram_din
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_WRITE = 2'd2
    } state_e;

    state_e            state_q, state_d;
    logic [2:0]        cnt_q, cnt_d;
    logic [2:0]        n_q, n_d;
    logic [RAM_AW-1:0] base_q, base_d;
    logic [31:0]       wdata_q, wdata_d;
    owner_e            owner_q, owner_d;
    logic [31:0]       rbuf_q, rbuf_d;
    logic [31:0]       if_data_q, if_data_d;
    logic [31:0]       mem_rdata_q, mem_rdata_d;
    logic              if_done_q, if_done_d;
    logic              mem_done_q, mem_done_d;
    logic [1:0]        lane;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        n_d         = n_q;
        base_d      = base_q;
        wdata_d     = wdata_q;
        owner_d     = owner_q;
        rbuf_d      = rbuf_q;
        if_data_d   = if_data_q;
        mem_rdata_d = mem_rdata_q;
        if_done_d   = 1'b0;
        mem_done_d  = 1'b0;
        ram_a       = '0;
        ram_wr      = WRITE_DISABLE;
        ram_dout    = '0;
        lane        = cnt_q[1:0] - 2'd1;

        case (state_q)
            ST_IDLE: begin
                // A done pulse blocks acceptance so a still-held request is not taken twice.
                if (!if_done_q && !mem_done_q) begin
                    if (mem_req) begin
                        base_d  = mem_addr[RAM_AW-1:0];
                        n_d     = len_bytes(mem_len);
                        wdata_d = mem_wdata;
                        owner_d = OWN_MEM;
                        cnt_d   = 3'd0;
                        rbuf_d  = '0;
                        state_d = mem_we ? ST_WRITE : ST_READ;
                    end else if (if_req) begin
                        base_d  = if_addr[RAM_AW-1:0];
                        n_d     = 3'd4;
                        owner_d = OWN_IF;
                        cnt_d   = 3'd0;
                        rbuf_d  = '0;
                        state_d = ST_READ;
                    end
                end
            end
            ST_READ: begin
                if (cnt_q != n_q) ram_a = base_q + RAM_AW'(cnt_q);
                if (cnt_q != 3'd0) rbuf_d[{lane, 3'b000} +: 8] = ram_din;
                if (cnt_q == n_q) begin
                    if (owner_q == OWN_MEM) begin
                        mem_rdata_d = rbuf_d;
                        mem_done_d  = 1'b1;
                    end else if (if_req) begin
                        if_data_d = rbuf_d;
                        if_done_d = 1'b1;
                    end
                    cnt_d   = 3'd0;
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + 3'd1;
                end
            end
            ST_WRITE: begin
                ram_wr   = WRITE_ENABLE;
                ram_a    = base_q + RAM_AW'(cnt_q);
                ram_dout = wdata_q[{cnt_q[1:0], 3'b000} +: 8];
                if (cnt_q == n_q - 3'd1) begin
                    mem_done_d = 1'b1;
                    cnt_d      = 3'd0;
                    state_d    = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + 3'd1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            n_q         <= '0;
            base_q      <= '0;
            wdata_q     <= '0;
            owner_q     <= OWN_IF;
            rbuf_q      <= '0;
            if_data_q   <= '0;
            mem_rdata_q <= '0;
            if_done_q   <= 1'b0;
            mem_done_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            n_q         <= n_d;
            base_q      <= base_d;
            wdata_q     <= wdata_d;
            owner_q     <= owner_d;
            rbuf_q      <= rbuf_d;
            if_data_q   <= if_data_d;
            mem_rdata_q <= mem_rdata_d;
            if_done_q   <= if_done_d;
            mem_done_q  <= mem_done_d;
        end
    end

    assign if_data      = if_data_q;
    assign if_done      = if_done_q;
    assign mem_rdata    = mem_rdata_q;
    assign mem_done     = mem_done_q;
    assign stallreq_if  = if_req & ~if_done_q;
    assign stallreq_mem = mem_req & ~mem_done_q;

endmodule

// File: tb/tb_mem_ctrl.sv
// Bench for mem_ctrl: byte-wide RAM model, table of MEM accesses with a
// load-data scoreboard, and hand sequences for arbitration/cancel/reset.
module tb_mem_ctrl;

    logic        clk, rst;
    logic        if_req, if_done, mem_req, mem_we, mem_done;
    logic [31:0] if_addr, if_data, mem_addr, mem_wdata, mem_rdata;
    logic [1:0]  mem_len;
    logic        stallreq_if, stallreq_mem, ram_wr;
    logic [31:0] ram_a;
    logic [7:0]  ram_dout, ram_din;

    mem_ctrl #(.RAM_AW(32)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_data(if_data), .if_done(if_done),
        .mem_req(mem_req), .mem_we(mem_we), .mem_len(mem_len), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_done(mem_done),
        .stallreq_if(stallreq_if), .stallreq_mem(stallreq_mem),
        .ram_a(ram_a), .ram_wr(ram_wr), .ram_dout(ram_dout), .ram_din(ram_din)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [7:0] ram [logic [31:0]];
    int wr_cnt = 0;

    always @(posedge clk) begin
        if (ram_wr) begin
            ram[ram_a] = ram_dout;
            wr_cnt++;
        end
        ram_din <= ram.exists(ram_a) ? ram[ram_a] : 8'h00;
    end

    function automatic logic [7:0] rd(input logic [31:0] a);
        return ram.exists(a) ? ram[a] : 8'h00;
    endfunction

    int n_tests = 0;
    int n_fail  = 0;
    logic [31:0] sb_q[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%h expected=%h", nm, act, exp);
        end
    endtask

    // Starts at posedge+1 (cycle 0); returns done cycle index or -1.
    task automatic run_mem(input logic we, input logic [1:0] len, input logic [31:0] addr,
                           input logic [31:0] wdata, output int lat);
        logic [31:0] exp;
        mem_req = 1'b1; mem_we = we; mem_len = len; mem_addr = addr; mem_wdata = wdata;
        lat = -1;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (mem_done) begin
                lat = k;
                if (!we) begin
                    if (sb_q.size() == 0) chk("sb_empty", 32'd1, 32'd0);
                    else begin
                        exp = sb_q.pop_front();
                        chk("mem_rdata", mem_rdata, exp);
                    end
                end
                break;
            end
            @(posedge clk); #1;
        end
        @(posedge clk); #1;
        mem_req = 1'b0;
    endtask

    typedef struct {
        logic        we;
        logic [1:0]  len;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        int          lat;
        int          nwr;
    } vec_t;

    vec_t vecs[9];

    initial begin
        int lat, w0, mdone, idone;

        rst = 1'b1; if_req = 0; if_addr = 0; mem_req = 0; mem_we = 0;
        mem_len = 0; mem_addr = 0; mem_wdata = 0;
        ram[32'h100] = 8'h13; ram[32'h101] = 8'h05; ram[32'h102] = 8'h00; ram[32'h103] = 8'h00;
        ram[32'h202] = 8'hAB; ram[32'h203] = 8'hCD;
        ram[32'h2] = 8'h11; ram[32'h4] = 8'h22;
        for (int i = 0; i < 4; i++) ram[32'h40 + i] = 8'hEE;

        // Reset state
        @(posedge clk); @(posedge clk); @(negedge clk);
        chk("rst_if_done", {31'd0, if_done}, 32'd0);
        chk("rst_mem_done", {31'd0, mem_done}, 32'd0);
        chk("rst_if_data", if_data, 32'd0);
        chk("rst_mem_rdata", mem_rdata, 32'd0);
        chk("rst_ram_wr", {31'd0, ram_wr}, 32'd0);
        chk("rst_ram_a", ram_a, 32'd0);
        chk("rst_ram_dout", {24'd0, ram_dout}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        // IF word fetch, cycle by cycle
        if_req = 1'b1; if_addr = 32'h100;
        for (int k = 0; k <= 6; k++) begin
            @(negedge clk);
            chk($sformatf("if_stall_c%0d", k), {31'd0, stallreq_if}, {31'd0, k <= 5});
            if (k >= 1 && k <= 4) chk($sformatf("if_ram_a_c%0d", k), ram_a, 32'h100 + k - 1);
            chk($sformatf("if_done_c%0d", k), {31'd0, if_done}, {31'd0, k == 6});
            if (k == 6) chk("if_data", if_data, 32'h00000513);
            @(posedge clk); #1;
        end
        if_req = 1'b0;
        @(posedge clk); #1;

        // Simultaneous IF and MEM: MEM wins
        mem_req = 1'b1; mem_we = 1'b0; mem_len = 2'b01; mem_addr = 32'h202;
        if_req = 1'b1; if_addr = 32'h100;
        sb_q.push_back(32'h0000CDAB);
        mdone = -1; idone = -1;
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            if (mem_done) begin
                mdone = k;
                chk("both_mem_rdata", mem_rdata, sb_q.pop_front());
            end
            if (k == 4) chk("both_if_stalled", {31'd0, stallreq_if}, 32'd1);
            if (if_done) begin
                idone = k;
                chk("both_if_data", if_data, 32'h00000513);
            end
            @(posedge clk); #1;
            if (mdone == k) mem_req = 1'b0;
            if (idone == k) begin
                if_req = 1'b0;
                break;
            end
        end
        mem_req = 1'b0; if_req = 1'b0;
        chk("both_mem_done_cyc", mdone, 32'd4);
        chk("both_if_done_cyc", idone, 32'd11);
        @(posedge clk); #1;

        // IF cancel, then re-request in cycle 6
        if_req = 1'b1; if_addr = 32'h100;
        for (int k = 0; k <= 5; k++) begin
            @(negedge clk);
            chk($sformatf("cancel_no_done_c%0d", k), {31'd0, if_done}, 32'd0);
            @(posedge clk); #1;
            if (k == 2) if_req = 1'b0;
        end
        if_req = 1'b1;
        idone = -1;
        for (int k = 6; k < 30; k++) begin
            @(negedge clk);
            if (if_done) begin
                idone = k;
                chk("cancel_refetch_data", if_data, 32'h00000513);
            end
            @(posedge clk); #1;
            if (idone == k) break;
        end
        if_req = 1'b0;
        chk("cancel_refetch_cyc", idone, 32'd12);
        @(posedge clk); #1;

        // Reset during a word store after two bytes
        w0 = wr_cnt;
        mem_req = 1'b1; mem_we = 1'b1; mem_len = 2'b10; mem_addr = 32'h40; mem_wdata = 32'h55667788;
        @(posedge clk); #1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1; mem_req = 1'b0;
        #1;
        chk("rstw_ram_wr", {31'd0, ram_wr}, 32'd0);
        chk("rstw_ram_a", ram_a, 32'd0);
        chk("rstw_ram_dout", {24'd0, ram_dout}, 32'd0);
        chk("rstw_mem_done", {31'd0, mem_done}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        chk("rstw_nwr", wr_cnt - w0, 32'd2);
        chk("rstw_b0", {24'd0, rd(32'h40)}, 32'h88);
        chk("rstw_b1", {24'd0, rd(32'h41)}, 32'h77);
        chk("rstw_b2", {24'd0, rd(32'h42)}, 32'hEE);
        chk("rstw_b3", {24'd0, rd(32'h43)}, 32'hEE);

        // Table of MEM accesses
        vecs[0] = '{1'b0, 2'b01, 32'h00000202, 32'h0,        32'h0000CDAB, 4, 0};
        vecs[1] = '{1'b1, 2'b00, 32'h00000003, 32'h0000007F, 32'h0,        2, 1};
        vecs[2] = '{1'b0, 2'b00, 32'h00000003, 32'h0,        32'h0000007F, 3, 0};
        vecs[3] = '{1'b1, 2'b10, 32'hFFFFFFFE, 32'hDEADBEEF, 32'h0,        5, 4};
        vecs[4] = '{1'b0, 2'b10, 32'hFFFFFFFE, 32'h0,        32'hDEADBEEF, 6, 0};
        vecs[5] = '{1'b0, 2'b01, 32'hFFFFFFFF, 32'h0,        32'h0000ADBE, 4, 0};
        vecs[6] = '{1'b0, 2'b11, 32'h00000100, 32'h0,        32'h00000513, 6, 0};
        vecs[7] = '{1'b1, 2'b01, 32'h00000010, 32'hFFFF1234, 32'h0,        3, 2};
        vecs[8] = '{1'b0, 2'b10, 32'h00000010, 32'h0,        32'h00001234, 6, 0};
        for (int i = 0; i < 9; i++) begin
            w0 = wr_cnt;
            if (!vecs[i].we) sb_q.push_back(vecs[i].rdata);
            run_mem(vecs[i].we, vecs[i].len, vecs[i].addr, vecs[i].wdata, lat);
            chk($sformatf("vec%0d_lat", i), lat, vecs[i].lat);
            chk($sformatf("vec%0d_nwr", i), wr_cnt - w0, vecs[i].nwr);
        end
        chk("byte_store_neighbor_lo", {24'd0, rd(32'h2)}, 32'h11);
        chk("byte_store_neighbor_hi", {24'd0, rd(32'h4)}, 32'h22);
        chk("wrap_b0", {24'd0, rd(32'h0)}, 32'hAD);
        chk("wrap_b1", {24'd0, rd(32'h1)}, 32'hDE);
        chk("sb_drained", sb_q.size(), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_ctrl.md
Name: mem_ctrl

Overview:
Arbiter and sequencer that shares the single 8-bit-wide, 1-cycle-read-latency RAM port between instruction fetch (IF) and the data memory stage (MEM). It serialises each 32/16/8-bit access into byte transfers and assembles read bytes little-endian. It returns a completion pulse to the requester and raises stall requests that ctrl uses to build the pipeline stall vector, the same vector pc_reg consumes.

Parameters:
RAM_AW, 32, width of ram_a; byte address space, wraps modulo 2^RAM_AW

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous active-high reset
if_req  in  1  IF fetch request, level, held until if_done
if_addr  in  32  fetch byte address; access is always a word
if_data  out  32  fetched word, valid while if_done=1
if_done  out  1  one-cycle completion pulse to IF
mem_req  in  1  MEM access request, level, held until mem_done
mem_we  in  1  1=store, 0=load
mem_len  in  2  00 byte, 01 half, 10 word (11 treated as word)
mem_addr  in  32  byte address, unaligned permitted
mem_wdata  in  32  store data; low N bytes used
mem_rdata  out  32  load data, zero-extended, valid while mem_done=1
mem_done  out  1  one-cycle completion pulse to MEM
stallreq_if  out  1  if_req & ~if_done (combinational)
stallreq_mem  out  1  mem_req & ~mem_done (combinational)
ram_a  out  RAM_AW  RAM byte address
ram_wr  out  1  RAM write strobe
ram_dout  out  8  RAM write data
ram_din  in  8  RAM read data for the address driven in the previous cycle

Behaviour:
- Reset (async, any state): state IDLE; cnt=0; if_done=mem_done=0; if_data=mem_rdata=0; ram_wr=0; ram_a=0; ram_dout=0. A write in progress is aborted; bytes already written stay in RAM.
- States: IDLE, READ, WRITE. N = byte count (1/2/4; 4 for IF).
- IDLE: requests are ignored in any cycle where if_done or mem_done is high (cool-down, so a held request is not re-accepted). Otherwise mem_req has priority over if_req. On accept edge: latch base address, N, wdata, and owner (IF/MEM); cnt<=0; go to READ (IF, or MEM load) or WRITE (MEM store).
- READ, cnt=0..N-1: ram_a=base+cnt, ram_wr=0. When cnt>=1, capture ram_din into byte lane cnt-1. cnt increments each cycle.
- READ, cnt=N: capture ram_din into lane N-1; ram_wr=0; set the owner's data register (upper lanes zero); pulse the owner's done; go to IDLE.
- Read latency: request seen in cycle 0, READ in cycles 1..N+1, done and data in cycle N+2 (word: cycle 6). Earliest next accept is cycle N+3.
- WRITE, cnt=0..N-1: ram_wr=1, ram_a=base+cnt, ram_dout=wdata[8*cnt+:8]. At cnt=N-1: pulse mem_done next cycle and go to IDLE. Store done is in cycle N+1.
- IF cancel (branch flush): if if_req is low at the final READ edge, the result is discarded and if_done stays 0; the FSM still completes. A MEM access cannot be cancelled.
- Address arithmetic is base+cnt, modulo 2^RAM_AW (0xFFFFFFFF+1 -> 0).
- Both requests in the same cycle: MEM served first; IF stays stalled (stallreq_if=1) and is accepted in the first non-cool-down IDLE cycle after mem_done.
- if_data and mem_rdata hold their last value outside done cycles.
- ram_wr is 0 in every state other than WRITE.

Decomposition:
- define.v gains: MemLenByte/MemLenHalf/MemLenWord encodings, RamAddrBus, RamDataBus (7:0), WriteEnable/WriteDisable.
- State encodings are local parameters.
- No sub-module: the byte counter and lane assembler are small enough to stay inline.

Test Plan:
- IF word read at 0x100, RAM model holds 0x13,0x05,0x00,0x00 -> ram_a 0x100..0x103 in cycles 1-4; if_done=1 with if_data=0x00000513 in cycle 6; stallreq_if=1 in cycles 0-5.
- if_req and mem_req (load half at 0x202, bytes 0xAB,0xCD) both rise in cycle 0 -> mem_done in cycle 4 with mem_rdata=0x0000CDAB; IF accepted in cycle 5; if_done in cycle 11.
- Store byte 0x7F to 0x3 -> exactly one cycle with ram_wr=1, ram_a=0x3, ram_dout=0x7F; mem_done in cycle 2; RAM elsewhere unchanged.
- IF fetch, if_req dropped in cycle 3 -> no if_done pulse; FSM returns to IDLE in cycle 6; a new if_req in cycle 6 is accepted in cycle 6.
- Store word 0xDEADBEEF at 0xFFFFFFFE -> writes EF@FFFFFFFE, BE@FFFFFFFF, AD@0, DE@1.
- rst pulsed after 2 bytes of a word store -> outputs zero immediately; only 2 bytes written; next request is accepted normally after rst deasserts.
